alu_operand_seq: RTL and testbench

ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

---
 rtl/alu_operand_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_operand_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_seq.sv
// Operand/opcode sequencer for a 4-bit ALU: keys step through A, B, SEL, EXEC and HOLD, and the result is captured and shown on a 7-segment digit.
// Optional key debounce is enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_operand_seq #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       key_next,
    input  logic       key_clr,
    input  logic [3:0] alu_result,
    input  logic       alu_cf,
    input  logic       alu_of,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] sel,
    output logic       op_valid,
    output logic [3:0] res_q,
    output logic       cf_q,
    output logic       of_q,
    output logic [2:0] state,
    output logic [7:0] op_count,
    output logic [6:0] hex_res
);

    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        LOAD_B   = 3'd1,
        LOAD_SEL = 3'd2,
        EXEC     = 3'd3,
        HOLD     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_lvl_d;
    logic [1:0]  w_lvl;
    logic [1:0]  w_edge;
    logic        w_next_p;
    logic        w_clr_p;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic [2:0]  r_sel;
    logic [3:0]  r_res;
    logic        r_cf;
    logic        r_of;
    logic [7:0]  r_cnt;
    logic [6:0]  r_hex;

    // Index 0 carries key_next, index 1 carries key_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {key_clr, key_next};
            r_sync2 <= r_sync1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    logic [1:0]  r_db;
    logic [19:0] r_db_cnt [2];

    // A level is accepted once it has differed from the accepted one for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db        <= 2'b00;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 20'd1;
                end
            end
        end
    end

    assign w_lvl = r_db;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^DEBOUNCE_CYCLES;
    assign w_lvl        = r_sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl_d <= 2'b00;
        end else begin
            r_lvl_d <= w_lvl;
        end
    end

    assign w_edge   = w_lvl & ~r_lvl_d;
    assign w_next_p = w_edge[0];
    assign w_clr_p  = w_edge[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Clear outranks advance; unused encodings fall back to LOAD_A.
    always_comb begin
        w_next_state = r_state;
        if (w_clr_p) begin
            w_next_state = LOAD_A;
        end else begin
            case (r_state)
                LOAD_A:   if (w_next_p) w_next_state = LOAD_B;
                LOAD_B:   if (w_next_p) w_next_state = LOAD_SEL;
                LOAD_SEL: if (w_next_p) w_next_state = EXEC;
                EXEC:     w_next_state = HOLD;
                HOLD:     if (w_next_p) w_next_state = LOAD_A;
                default:  w_next_state = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_sel <= 3'd0;
            r_res <= 4'd0;
            r_cf  <= 1'b0;
            r_of  <= 1'b0;
            r_cnt <= 8'd0;
        end else if (w_clr_p) begin
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_sel <= 3'd0;
            r_res <= 4'd0;
            r_cf  <= 1'b0;
            r_of  <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A:   if (w_next_p) r_a <= sw;
                LOAD_B:   if (w_next_p) r_b <= sw;
                LOAD_SEL: if (w_next_p) r_sel <= sw[2:0];
                EXEC: begin
                    r_res <= alu_result;
                    r_cf  <= alu_cf;
                    r_of  <= alu_of;
                    r_cnt <= r_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] f_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex <= 7'h7F;
        end else begin
            r_hex <= (r_state == HOLD) ? f_seg(r_res) : 7'h7F;
        end
    end

    assign a        = r_a;
    assign b        = r_b;
    assign sel      = r_sel;
    assign op_valid = (r_state == EXEC);
    assign res_q    = r_res;
    assign cf_q     = r_cf;
    assign of_q     = r_of;
    assign state    = r_state;
    assign op_count = r_cnt;
    assign hex_res  = r_hex;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a small ALU model (add, subtract, and).
module tb_alu_operand_seq;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif
    localparam int HOLD_CYC = DEB + 3;
    localparam int REL_CYC  = DEB + 4;
    localparam int LAT      = DEB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = 4'd0;
    logic       key_next = 1'b0;
    logic       key_clr = 1'b0;
    logic [3:0] alu_result;
    logic       alu_cf;
    logic       alu_of;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic       op_valid;
    logic [3:0] res_q;
    logic       cf_q;
    logic       of_q;
    logic [2:0] state;
    logic [7:0] op_count;
    logic [6:0] hex_res;

    int n_tests = 0;
    int n_fail  = 0;

    alu_operand_seq #(.DEBOUNCE_CYCLES(20'd4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .key_next(key_next), .key_clr(key_clr),
        .alu_result(alu_result), .alu_cf(alu_cf), .alu_of(alu_of),
        .a(a), .b(b), .sel(sel), .op_valid(op_valid), .res_q(res_q),
        .cf_q(cf_q), .of_q(of_q), .state(state), .op_count(op_count), .hex_res(hex_res)
    );

    always #5 clk = ~clk;

    // Downstream ALU: sel 0 add, 1 subtract (cf = borrow), otherwise bitwise and.
    always_comb begin
        logic [4:0] t;
        t          = 5'd0;
        alu_result = 4'd0;
        alu_cf     = 1'b0;
        alu_of     = 1'b0;
        case (sel)
            3'd0: begin
                t          = {1'b0, a} + {1'b0, b};
                alu_result = t[3:0];
                alu_cf     = t[4];
                alu_of     = (a[3] == b[3]) && (t[3] != a[3]);
            end
            3'd1: begin
                t          = {1'b0, a} - {1'b0, b};
                alu_result = t[3:0];
                alu_cf     = t[4];
                alu_of     = (a[3] != b[3]) && (t[3] != a[3]);
            end
            default: alu_result = a & b;
        endcase
    end

    task automatic press_next(input logic [3:0] v);
        @(negedge clk);
        sw       = v;
        key_next = 1'b1;
        repeat (HOLD_CYC) @(negedge clk);
        key_next = 1'b0;
        repeat (REL_CYC) @(negedge clk);
    endtask

    task automatic press_keys(input logic nxt, input logic clr);
        @(negedge clk);
        key_next = nxt;
        key_clr  = clr;
        repeat (HOLD_CYC) @(negedge clk);
        key_next = 1'b0;
        key_clr  = 1'b0;
        repeat (REL_CYC) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (state !== 3'd0 || a !== 4'd0 || b !== 4'd0 || sel !== 3'd0 || op_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: state=%0d a=%0h b=%0h sel=%0d op_valid=%0b, required 0 0 0 0 0", state, a, b, sel, op_valid);
        end
        n_tests++;
        if (res_q !== 4'd0 || cf_q !== 1'b0 || of_q !== 1'b0 || op_count !== 8'd0 || hex_res !== 7'h7F) begin
            n_fail++;
            $display("FAIL reset_res: res=%0h cf=%0b of=%0b cnt=%0d hex=%h, required 0 0 0 0 7f", res_q, cf_q, of_q, op_count, hex_res);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_add;
        int vld;
        @(negedge clk);
        sw       = 4'd3;
        key_next = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL latency_early: state=%0d, required 0", state);
        end
        @(negedge clk);
        n_tests++;
        if (state !== 3'd1 || a !== 4'd3) begin
            n_fail++;
            $display("FAIL latency_step: state=%0d a=%0h, required 1 3", state, a);
        end
        repeat (HOLD_CYC - LAT) @(negedge clk);
        key_next = 1'b0;
        repeat (REL_CYC) @(negedge clk);
        press_next(4'd5);
        n_tests++;
        if (state !== 3'd2 || b !== 4'd5) begin
            n_fail++;
            $display("FAIL load_b: state=%0d b=%0h, required 2 5", state, b);
        end
        @(negedge clk);
        sw       = 4'd0;
        key_next = 1'b1;
        vld      = 0;
        for (int i = 0; i < HOLD_CYC + REL_CYC; i++) begin
            @(negedge clk);
            if (i == HOLD_CYC - 1) key_next = 1'b0;
            if (op_valid) vld++;
        end
        n_tests++;
        if (vld != 1) begin
            n_fail++;
            $display("FAIL op_valid_width: %0d cycles, required 1", vld);
        end
        n_tests++;
        if (state !== 3'd4 || a !== 4'd3 || b !== 4'd5 || sel !== 3'd0) begin
            n_fail++;
            $display("FAIL add_operands: state=%0d a=%0h b=%0h sel=%0d, required 4 3 5 0", state, a, b, sel);
        end
        n_tests++;
        if (res_q !== 4'h8 || cf_q !== 1'b0 || of_q !== 1'b1 || hex_res !== 7'h00 || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL add_result: res=%0h cf=%0b of=%0b hex=%h cnt=%0d, required 8 0 1 00 1", res_q, cf_q, of_q, hex_res, op_count);
        end
    endtask

    task automatic test_sub;
        press_next(4'd0);
        n_tests++;
        if (state !== 3'd0 || res_q !== 4'h8 || hex_res !== 7'h7F) begin
            n_fail++;
            $display("FAIL hold_exit: state=%0d res=%0h hex=%h, required 0 8 7f", state, res_q, hex_res);
        end
        press_next(4'd2);
        press_next(4'd3);
        press_next(4'd1);
        n_tests++;
        if (res_q !== 4'hF || cf_q !== 1'b1 || of_q !== 1'b0 || hex_res !== 7'h0E || op_count !== 8'd2) begin
            n_fail++;
            $display("FAIL sub_result: res=%0h cf=%0b of=%0b hex=%h cnt=%0d, required f 1 0 0e 2", res_q, cf_q, of_q, hex_res, op_count);
        end
    endtask

    task automatic test_clr;
        press_next(4'd0);
        press_next(4'd7);
        press_next(4'd9);
        n_tests++;
        if (state !== 3'd2 || a !== 4'd7 || b !== 4'd9) begin
            n_fail++;
            $display("FAIL clr_setup: state=%0d a=%0h b=%0h, required 2 7 9", state, a, b);
        end
        press_keys(1'b0, 1'b1);
        n_tests++;
        if (state !== 3'd0 || a !== 4'd0 || b !== 4'd0 || sel !== 3'd0 || res_q !== 4'd0 || cf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_regs: state=%0d a=%0h b=%0h sel=%0d res=%0h cf=%0b, required all 0", state, a, b, sel, res_q, cf_q);
        end
        n_tests++;
        if (op_count !== 8'd2) begin
            n_fail++;
            $display("FAIL clr_count: cnt=%0d, required 2", op_count);
        end
    endtask

    task automatic test_clr_next;
        press_next(4'd4);
        @(negedge clk);
        sw = 4'd6;
        press_keys(1'b1, 1'b1);
        n_tests++;
        if (state !== 3'd0 || b !== 4'd0 || a !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_wins: state=%0d a=%0h b=%0h, required 0 0 0", state, a, b);
        end
    endtask

    task automatic test_rst_exec;
        bit seen;
        press_next(4'd1);
        press_next(4'd1);
        @(negedge clk);
        sw       = 4'd0;
        key_next = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (state == 3'd3) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL exec_reached: state=%0d, required 3 within 40 cycles", state);
        end
        rst = 1'b1;
        @(negedge clk);
        key_next = 1'b0;
        n_tests++;
        if (res_q !== 4'd0 || op_count !== 8'd0 || hex_res !== 7'h7F || state !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_in_exec: res=%0h cnt=%0d hex=%h state=%0d, required 0 0 7f 0", res_q, op_count, hex_res, state);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (REL_CYC) @(negedge clk);
    endtask

    task automatic test_wrap;
        for (int n = 0; n < 256; n++) begin
            press_next(4'd1);
            press_next(4'd2);
            press_next(4'd2);
            if (n == 254) begin
                n_tests++;
                if (op_count !== 8'd255 || res_q !== 4'd0) begin
                    n_fail++;
                    $display("FAIL count_255: cnt=%0d res=%0h, required 255 0", op_count, res_q);
                end
            end
            press_next(4'd0);
        end
        n_tests++;
        if (op_count !== 8'd0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL count_wrap: cnt=%0d state=%0d, required 0 0", op_count, state);
        end
    endtask

`ifdef ALU_SEQ_DEBOUNCE_EN
    task automatic test_debounce;
        @(negedge clk);
        sw       = 4'd5;
        key_next = 1'b1;
        repeat (3) @(negedge clk);
        key_next = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL db_glitch: state=%0d, required 0", state);
        end
        key_next = 1'b1;
        repeat (6) @(negedge clk);
        key_next = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (state !== 3'd1 || a !== 4'd5) begin
            n_fail++;
            $display("FAIL db_press: state=%0d a=%0h, required 1 5", state, a);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_clr;
        test_clr_next;
        test_rst_exec;
        test_wrap;
`ifdef ALU_SEQ_DEBOUNCE_EN
        test_debounce;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
